serial_tx: RTL

Master-side serial transmit and encode block, the far-end partner of the slave receiver. It samples the control word (IsPro, IsMaster, RawPls, Option[2:0]) once per symbol and builds a parity-protected byte. The byte is 8b10b encoded with running disparity, and a K28.5 comma is inserted once every 256 symbols. The result is serialized at 20 Mbps from the 60 MHz master clock onto the SFP TX data pin.

---
 rtl/serial_tx_pkg.sv | 41 ++++
 rtl/serial_tx_encode_8b10b.sv | 104 ++++++++++
 rtl/serial_tx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_tx_pkg.sv
// ----------------------------------------------------------------------------
// serial_tx_pkg : shared constants for the serial TX/RX pair
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package serial_tx_pkg;

  localparam int SYM_BITS = 10;

  localparam logic [SYM_BITS-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [SYM_BITS-1:0] K28_5_RDP = 10'b1100000101;
  localparam logic [7:0]          K28_5_BYTE = 8'hBC;

  localparam int BIT_PRO    = 7;
  localparam int BIT_MST    = 6;
  localparam int BIT_PLS    = 5;
  localparam int BIT_P1     = 4;
  localparam int BIT_OPT_HI = 3;
  localparam int BIT_OPT_LO = 1;
  localparam int BIT_P2     = 0;

  // Both nibbles carry odd parity so an all-zero byte can never appear.
  function automatic logic [7:0] build_byte(input logic       pro,
                                            input logic       mst,
                                            input logic       pls,
                                            input logic [2:0] opt);
    logic [7:0] b;
    b                         = '0;
    b[BIT_PRO]                = pro;
    b[BIT_MST]                = mst;
    b[BIT_PLS]                = pls;
    b[BIT_P1]                 = ~(pro ^ mst ^ pls);
    b[BIT_OPT_HI:BIT_OPT_LO]  = opt;
    b[BIT_P2]                 = ~(^opt);
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_tx_encode_8b10b.sv
// ----------------------------------------------------------------------------
// encode_8b10b : combinational 8b10b encoder, output order {a,b,c,d,e,i,f,g,h,j}
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module encode_8b10b
  import serial_tx_pkg::*;
(
  input  logic [7:0]          datain,
  input  logic                kin,
  input  logic                dispin,
  output logic [SYM_BITS-1:0] dataout,
  output logic                dispout
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] six_n, six_p, six;
  logic [3:0] four_n, four_p, four;
  logic       k28, rd_mid, use_a7;

  assign x   = datain[4:0];
  assign y   = datain[7:5];
  assign k28 = kin && (x == 5'd28);

  always_comb begin
    six_n = 6'b000000;
    six_p = 6'b000000;
    case (x)
      5'd0:  begin six_n = 6'b100111; six_p = 6'b011000; end
      5'd1:  begin six_n = 6'b011101; six_p = 6'b100010; end
      5'd2:  begin six_n = 6'b101101; six_p = 6'b010010; end
      5'd3:  begin six_n = 6'b110001; six_p = 6'b110001; end
      5'd4:  begin six_n = 6'b110101; six_p = 6'b001010; end
      5'd5:  begin six_n = 6'b101001; six_p = 6'b101001; end
      5'd6:  begin six_n = 6'b011001; six_p = 6'b011001; end
      5'd7:  begin six_n = 6'b111000; six_p = 6'b000111; end
      5'd8:  begin six_n = 6'b111001; six_p = 6'b000110; end
      5'd9:  begin six_n = 6'b100101; six_p = 6'b100101; end
      5'd10: begin six_n = 6'b010101; six_p = 6'b010101; end
      5'd11: begin six_n = 6'b110100; six_p = 6'b110100; end
      5'd12: begin six_n = 6'b001101; six_p = 6'b001101; end
      5'd13: begin six_n = 6'b101100; six_p = 6'b101100; end
      5'd14: begin six_n = 6'b011100; six_p = 6'b011100; end
      5'd15: begin six_n = 6'b010111; six_p = 6'b101000; end
      5'd16: begin six_n = 6'b011011; six_p = 6'b100100; end
      5'd17: begin six_n = 6'b100011; six_p = 6'b100011; end
      5'd18: begin six_n = 6'b010011; six_p = 6'b010011; end
      5'd19: begin six_n = 6'b110010; six_p = 6'b110010; end
      5'd20: begin six_n = 6'b001011; six_p = 6'b001011; end
      5'd21: begin six_n = 6'b101010; six_p = 6'b101010; end
      5'd22: begin six_n = 6'b011010; six_p = 6'b011010; end
      5'd23: begin six_n = 6'b111010; six_p = 6'b000101; end
      5'd24: begin six_n = 6'b110011; six_p = 6'b001100; end
      5'd25: begin six_n = 6'b100110; six_p = 6'b100110; end
      5'd26: begin six_n = 6'b010110; six_p = 6'b010110; end
      5'd27: begin six_n = 6'b110110; six_p = 6'b001001; end
      5'd28: begin six_n = 6'b001110; six_p = 6'b001110; end
      5'd29: begin six_n = 6'b101110; six_p = 6'b010001; end
      5'd30: begin six_n = 6'b011110; six_p = 6'b100001; end
      default: begin six_n = 6'b101011; six_p = 6'b010100; end
    endcase
    if (k28) begin
      six_n = 6'b001111;
      six_p = 6'b110000;
    end
    six    = dispin ? six_p : six_n;
    rd_mid = dispin ^ ($countones(six) != 3);

    // The alternate x.7 avoids a run of five equal bits across the e/i-f boundary.
    use_a7 = (y == 3'd7) &&
             (kin ||
              (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
              ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));

    four_n = 4'b0000;
    four_p = 4'b0000;
    case (y)
      3'd0: begin four_n = 4'b1011; four_p = 4'b0100; end
      3'd1: begin four_n = 4'b1001; four_p = 4'b1001; end
      3'd2: begin four_n = 4'b0101; four_p = 4'b0101; end
      3'd3: begin four_n = 4'b1100; four_p = 4'b0011; end
      3'd4: begin four_n = 4'b1101; four_p = 4'b0010; end
      3'd5: begin four_n = 4'b1010; four_p = 4'b1010; end
      3'd6: begin four_n = 4'b0110; four_p = 4'b0110; end
      default: begin four_n = 4'b1110; four_p = 4'b0001; end
    endcase
    if (use_a7) begin
      four_n = 4'b0111;
      four_p = 4'b1000;
    end

    // K28.y is the only code whose f..j is the complement of the data form at RD+.
    if (k28) four = dispin ? ~four_p : four_p;
    else     four = rd_mid ? four_p : four_n;

    dataout = {six, four};
    dispout = rd_mid ^ ($countones(four) != 2);
  end

endmodule

`default_nettype wire

// File: rtl/serial_tx.sv
// ----------------------------------------------------------------------------
// serial_tx : control word -> parity byte -> 8b10b with K28.5 framing -> line.
// Optional macro SERIAL_TX_INPUT_SYNC_EN adds 2-FF input synchronizers. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int CLK_PER_BIT   = 3,
  parameter int SYM_PER_FRAME = 256
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_IsPro,
  input  logic       i_IsMaster,
  input  logic       i_RawPls,
  input  logic [2:0] i_Option,
  output logic       o_SerialData,
  output logic       o_tx_dis,
  output logic [1:0] o_tx_led
);

  localparam int              DIV_W      = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_PER_BIT - 1);
  localparam logic [7:0]      FRAME_LAST = 8'(SYM_PER_FRAME - 1);
  localparam logic [3:0]      BIT_LAST   = 4'(SYM_BITS - 1);

  logic [5:0] ctrl_raw, ctrl;
  assign ctrl_raw = {i_IsPro, i_IsMaster, i_RawPls, i_Option};

`ifdef SERIAL_TX_INPUT_SYNC_EN
  logic [5:0] sync1_q, sync2_q;
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ctrl_raw;
      sync2_q <= sync1_q;
    end
  end
  assign ctrl = sync2_q;
`else
  assign ctrl = ctrl_raw;
`endif

  logic [DIV_W-1:0]    bit_div_q, bit_div_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          sym_cnt_q, sym_cnt_d;
  logic [SYM_BITS-1:0] shreg_q,   shreg_d;
  logic                rd_q,      rd_d;
  logic                serial_q,  serial_d;
  logic                hb_q,      hb_d;
  logic                pls_q,     pls_d;

  logic                bit_tick, sym_load, is_comma;
  logic [7:0]          enc_byte;
  logic [SYM_BITS-1:0] enc_code;
  logic                enc_disp;

  assign bit_tick = (bit_div_q == DIV_MAX);
  assign sym_load = bit_tick && (bit_cnt_q == BIT_LAST);
  assign is_comma = (sym_cnt_q == FRAME_LAST);
  assign enc_byte = is_comma ? K28_5_BYTE : build_byte(ctrl[5], ctrl[4], ctrl[3], ctrl[2:0]);

  encode_8b10b u_enc (
    .datain  (enc_byte),
    .kin     (is_comma),
    .dispin  (rd_q),
    .dataout (enc_code),
    .dispout (enc_disp)
  );

  always_comb begin
    bit_div_d = bit_div_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    sym_cnt_d = sym_cnt_q;
    shreg_d   = shreg_q;
    rd_d      = rd_q;
    serial_d  = serial_q;
    hb_d      = hb_q;
    pls_d     = pls_q;
    if (bit_tick) begin
      bit_div_d = '0;
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? 4'd0 : bit_cnt_q + 4'd1;
      serial_d  = shreg_q[SYM_BITS-1];
      shreg_d   = shreg_q << 1;
    end
    // A load replaces the shift that would happen on the same tick.
    if (sym_load) begin
      shreg_d   = enc_code;
      rd_d      = enc_disp;
      sym_cnt_d = sym_cnt_q + 8'd1;
      if (is_comma) hb_d  = ~hb_q;
      else          pls_d = ctrl[3];
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      bit_div_q <= '0;
      bit_cnt_q <= '0;
      sym_cnt_q <= 8'hFF;
      shreg_q   <= '0;
      rd_q      <= 1'b0;
      serial_q  <= 1'b0;
      hb_q      <= 1'b0;
      pls_q     <= 1'b0;
    end else begin
      bit_div_q <= bit_div_d;
      bit_cnt_q <= bit_cnt_d;
      sym_cnt_q <= sym_cnt_d;
      shreg_q   <= shreg_d;
      rd_q      <= rd_d;
      serial_q  <= serial_d;
      hb_q      <= hb_d;
      pls_q     <= pls_d;
    end
  end

  assign o_SerialData = serial_q;
  assign o_tx_dis     = 1'b0;
  assign o_tx_led     = {pls_q, hb_q};

endmodule

`default_nettype wire
